// File: rtl/uart_rx_pkg.sv
// Shared types and widths for the UART receive front end.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned BAUD_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } t_rx_state;

endpackage

// File: rtl/uart_rx_frame_fifo.sv
// Show-ahead synchronous FIFO: head always presents the oldest entry.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LOG2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [LOG2_DEPTH:0]   count
);

    localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;
    localparam int unsigned CNT_W = LOG2_DEPTH + 1;
    localparam int unsigned PTR_W = LOG2_DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with input synchroniser, framing/overflow flags and a
// show-ahead byte FIFO feeding the command parser.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT    = 434,
    parameter int unsigned LOG2_FIFO_DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_i,
    input  logic                       rd_en,
    output logic [DATA_BITS-1:0]       rx_data,
    output logic                       rx_valid,
    output logic [LOG2_FIFO_DEPTH:0]   fifo_count,
    output logic                       frame_err,
    output logic                       overflow
);

    localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);
    localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0]  IDX_LAST  = BIT_IDX_W'(DATA_BITS - 1);

    logic                   rx_meta;
    logic                   rx_s;
    t_rx_state              state;
    logic [BAUD_CNT_W-1:0]  baud_cnt;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   stop_sample_c;
    logic                   push_c;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Push lands in the FIFO on the stop-sample edge so the byte shows next cycle.
    assign stop_sample_c = (state == STOP) && (baud_cnt == BIT_LAST);
    assign push_c        = stop_sample_c && rx_s;
    assign rx_valid      = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + BIT_IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            state    <= IDLE;
                            overflow <= fifo_full && !(rd_en && rx_valid);
                        end else begin
                            state     <= WAIT_HIGH;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH      (DATA_BITS),
        .LOG2_DEPTH (LOG2_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data (shift_reg),
        .pop       (rd_en),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frame table plus hand-timed corner sequences.
module tb_uart_rx_frame;

    localparam int unsigned CPB  = 8;
    localparam int unsigned LOG2 = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            rx_i;
    logic            rd_en;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [LOG2:0]   fifo_count;
    logic            frame_err;
    logic            overflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          fe_cnt   = 0;
    int          ov_cnt   = 0;
    int          both_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop_val;
        int         stop_bits;
        int         gap;
        int         exp_count;
        logic       exp_valid;
        logic [7:0] exp_head;
        int         exp_fe;
        int         exp_ov;
    } vec_t;

    vec_t vecs [8];

    uart_rx_frame #(
        .CLKS_PER_BIT    (CPB),
        .LOG2_FIFO_DEPTH (LOG2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .rd_en      (rd_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Pulse counters for the one-cycle flags.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overflow) ov_cnt++;
        if (frame_err && overflow) both_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic idle_bits(input int n);
        rx_i = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int stop_bits, input int gap);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stop_val;
        repeat (stop_bits * CPB) @(negedge clk);
        rx_i = 1'b1;
        repeat (gap * CPB) @(negedge clk);
    endtask

    task automatic pop_check(input logic [7:0] exp, input string name);
        check({name, " valid"}, 32'(rx_valid), 32'd1);
        check({name, " data"}, 32'(rx_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic check_empty(input string name);
        check({name, " count"}, 32'(fifo_count), 32'd0);
        check({name, " valid"}, 32'(rx_valid), 32'd0);
    endtask

    task automatic run_rows(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            int fe0;
            int ov0;
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send_frame(vecs[r].data, vecs[r].stop_val, vecs[r].stop_bits, vecs[r].gap);
            check($sformatf("row%0d count", r), 32'(fifo_count), 32'(vecs[r].exp_count));
            check($sformatf("row%0d valid", r), 32'(rx_valid), 32'(vecs[r].exp_valid));
            if (vecs[r].exp_valid)
                check($sformatf("row%0d head", r), 32'(rx_data), 32'(vecs[r].exp_head));
            check($sformatf("row%0d frame_err pulses", r), 32'(fe_cnt - fe0), 32'(vecs[r].exp_fe));
            check($sformatf("row%0d overflow pulses", r), 32'(ov_cnt - ov0), 32'(vecs[r].exp_ov));
        end
    endtask

    initial begin
        int fe0;
        int ov0;

        vecs[0] = '{8'hA5, 1'b1, 1,  2, 1, 1'b1, 8'hA5, 0, 0};
        vecs[1] = '{8'h3C, 1'b0, 20, 2, 0, 1'b0, 8'h00, 1, 0};
        vecs[2] = '{8'h11, 1'b1, 1,  2, 1, 1'b1, 8'h11, 0, 0};
        vecs[3] = '{8'h01, 1'b1, 1,  0, 1, 1'b1, 8'h01, 0, 0};
        vecs[4] = '{8'h02, 1'b1, 1,  0, 2, 1'b1, 8'h01, 0, 0};
        vecs[5] = '{8'h03, 1'b1, 1,  0, 3, 1'b1, 8'h01, 0, 0};
        vecs[6] = '{8'h04, 1'b1, 1,  0, 4, 1'b1, 8'h01, 0, 0};
        vecs[7] = '{8'h05, 1'b1, 1,  2, 4, 1'b1, 8'h01, 0, 1};

        rst   = 1'b1;
        rx_i  = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check_empty("reset");
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        idle_bits(1);

        // Single good frame, then pop it.
        run_rows(0, 0);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        pop_check(8'hA5, "s1 pop");
        check_empty("s1 after pop");

        // Start-bit glitch shorter than half a bit.
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check_empty("s2 glitch");
        check("s2 flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

        // Pop on an empty FIFO is ignored.
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("empty pop count", 32'(fifo_count), 32'd0);

        // Long break on the stop bit, then recovery.
        run_rows(1, 2);
        pop_check(8'h11, "s3 pop");
        check_empty("s3 after pop");

        // Overfill: fifth byte is dropped.
        run_rows(3, 7);
        pop_check(8'h01, "s4 pop0");
        pop_check(8'h02, "s4 pop1");
        pop_check(8'h03, "s4 pop2");
        pop_check(8'h04, "s4 pop3");
        check_empty("s4 drained");

        // Pop coinciding with the push cycle of a byte arriving while full.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1, 0);
        idle_bits(1);
        check("s5 filled count", 32'(fifo_count), 32'd4);
        ov0 = ov_cnt;
        fork
            send_frame(8'h77, 1'b1, 1, 2);
            begin
                repeat (78) @(negedge clk);
                check("s5 pre-push count", 32'(fifo_count), 32'd4);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                check("s5 push cycle count", 32'(fifo_count), 32'd4);
            end
        join
        check("s5 overflow pulses", 32'(ov_cnt - ov0), 32'd0);
        check("s5 count", 32'(fifo_count), 32'd4);
        pop_check(8'h02, "s5 pop0");
        pop_check(8'h03, "s5 pop1");
        pop_check(8'h04, "s5 pop2");
        pop_check(8'h77, "s5 pop3");
        check_empty("s5 drained");

        // Reset in the middle of bit 4 of 0x5A, with a byte already buffered.
        send_frame(8'h99, 1'b1, 1, 2);
        check("s6 pre count", 32'(fifo_count), 32'd1);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_i = (i % 2 == 1);
            repeat (CPB) @(negedge clk);
        end
        rx_i = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_empty("s6 in reset");
        check("s6 reset rx_data", 32'(rx_data), 32'd0);
        check("s6 reset flags", 32'({frame_err, overflow}), 32'd0);
        rst = 1'b0;
        idle_bits(6);
        check_empty("s6 abandoned frame");
        check("s6 flag pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
        send_frame(8'hC3, 1'b1, 1, 2);
        check("s6 count", 32'(fifo_count), 32'd1);
        pop_check(8'hC3, "s6 pop");
        check_empty("s6 drained");

        check("flags never coincide", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
